// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared constants and request kinds for the MM memory server.
// Revision    : 1.0
// ============================================================================
package mm_pkg;

    localparam int MM_N = 20;
    localparam int HDR  = 3;

    typedef enum logic [2:0] {
        REQ_IDLE = 3'd0,
        REQ_A    = 3'd1,
        REQ_B    = 3'd2,
        REQ_HDR  = 3'd3,
        REQ_WR   = 3'd4
    } req_kind_e;

endpackage
`default_nettype wire

// File: rtl/mm_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mm_addr_gen
// Description : Request decode, operand address arithmetic and range check.
// Revision    : 1.0
// ============================================================================
module mm_addr_gen
    import mm_pkg::*;
#(
    parameter int N     = MM_N,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic          read,
    input  logic          write,
    input  logic          index,
    input  logic [N-1:0]  i,
    input  logic [N-1:0]  j,
    input  logic [N-1:0]  r1,
    input  logic [N-1:0]  c1,
    input  logic [N-1:0]  c2,
    output req_kind_e     kind,
    output logic [AW-1:0] addr,
    output logic          hit,
    output logic          err
);

    // 2N+1 bits holds the worst-case B address without wrap-around.
    localparam int FW = 2*N + 1;
    localparam logic [FW-1:0] c_depth = FW'(DEPTH);
    localparam logic [FW-1:0] c_hdr   = FW'(HDR);

    logic [FW-1:0] w_base;
    logic [FW-1:0] w_full;

    always_comb begin
        kind   = REQ_IDLE;
        w_full = '0;
        hit    = 1'b0;
        err    = 1'b0;
        w_base = FW'(j) + c_hdr;
        case ({read, write})
            2'b10: begin
                if (index) begin
                    kind   = REQ_B;
                    w_full = FW'(i) * FW'(c2) + w_base + FW'(r1) * FW'(c1);
                end else begin
                    kind   = REQ_A;
                    w_full = FW'(i) * FW'(c1) + w_base;
                end
                err = (w_full >= c_depth);
                hit = !err;
            end
            2'b11: begin
                kind   = REQ_HDR;
                w_full = FW'(i);
                hit    = (w_full < c_hdr);
            end
            2'b01:   kind = REQ_WR;
            default: kind = REQ_IDLE;
        endcase
    end

    assign addr = w_full[AW-1:0];

endmodule
`default_nettype wire

// File: rtl/mm_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : mm_mem_server
// Description : Operand image and result buffer responder for the MM core.
// Revision    : 1.0
// ============================================================================
module mm_mem_server
    import mm_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int DEPTH  = 1024,
    parameter int RDEPTH = 1024,
    parameter int AW     = $clog2(DEPTH),
    parameter int RW     = $clog2(RDEPTH)
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           read,
    input  logic           write,
    input  logic           index,
    input  logic [N-1:0]   i,
    input  logic [N-1:0]   j,
    output logic [N-1:0]   read_data,
    input  logic [2*N-1:0] write_data,
    input  logic           finish,
    input  logic           load_en,
    input  logic [AW-1:0]  load_addr,
    input  logic [N-1:0]   load_data,
    input  logic [RW-1:0]  res_addr,
    output logic [2*N-1:0] res_data,
    output logic [RW:0]    wr_count,
    output logic           done,
    output logic           overflow,
    output logic           addr_err
);

    localparam logic [RW:0] c_rdepth = (RW+1)'(RDEPTH);
    localparam logic [RW:0] c_one    = (RW+1)'(1);

    logic [N-1:0]   r_mem     [DEPTH];
    logic [2*N-1:0] r_res_mem [RDEPTH];
    logic [N-1:0]   r_r1;
    logic [N-1:0]   r_c1;
    logic [N-1:0]   r_c2;

    logic [N-1:0]   r_read_data;
    logic [2*N-1:0] r_res_data;
    logic [RW:0]    r_wr_count;
    logic           r_done;
    logic           r_overflow;
    logic           r_addr_err;
    logic           r_finish_q;

    req_kind_e      w_kind;
    logic [AW-1:0]  w_addr;
    logic           w_hit;
    logic           w_err;
    logic           w_full;
    logic           w_wr_en;

    mm_addr_gen #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_gen (
        .read  (read),
        .write (write),
        .index (index),
        .i     (i),
        .j     (j),
        .r1    (r_r1),
        .c1    (r_c1),
        .c2    (r_c2),
        .kind  (w_kind),
        .addr  (w_addr),
        .hit   (w_hit),
        .err   (w_err)
    );

    assign w_full  = (r_wr_count == c_rdepth);
    assign w_wr_en = !reset && (w_kind == REQ_WR) && !r_done && !w_full;

    // Storage keeps its contents through reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
            if (load_addr == AW'(0)) r_r1 <= load_data;
            if (load_addr == AW'(1)) r_c1 <= load_data;
            if (load_addr == AW'(2)) r_c2 <= load_data;
        end
        if (w_wr_en) begin
            r_res_mem[r_wr_count[RW-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= '0;
            r_res_data  <= '0;
            r_wr_count  <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_addr_err  <= 1'b0;
            r_finish_q  <= 1'b0;
        end else begin
            r_finish_q <= finish;
            if (finish && !r_finish_q) r_done <= 1'b1;

            r_read_data <= w_hit ? r_mem[w_addr] : '0;
            if (w_err) r_addr_err <= 1'b1;

            if ((w_kind == REQ_WR) && !r_done) begin
                if (w_full) r_overflow <= 1'b1;
                else        r_wr_count <= r_wr_count + c_one;
            end

            r_res_data <= r_res_mem[res_addr];
        end
    end

    assign read_data = r_read_data;
    assign res_data  = r_res_data;
    assign wr_count  = r_wr_count;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mm_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_mem_server
// Description : Directed bench with a reference model for mm_mem_server.
// Revision    : 1.0
// ============================================================================
module tb_mm_mem_server;

    localparam int N     = 20;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          read = 1'b0, write = 1'b0, index = 1'b0, finish = 1'b0, load_en = 1'b0;
    logic [N-1:0]  i = '0, j = '0, load_data = '0;
    logic [2*N-1:0] write_data = '0;
    logic [9:0]    load_addr = '0, res_addr = '0;

    logic [N-1:0]   rd_b, rd_s;
    logic [2*N-1:0] res_b, res_s;
    logic [10:0]    cnt_b;
    logic [2:0]     cnt_s;
    logic           done_b, done_s, ovf_b, ovf_s, err_b, err_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mm_mem_server #(.N(N), .DEPTH(DEPTH), .RDEPTH(1024)) u_big (
        .clk(clk), .reset(reset), .read(read), .write(write), .index(index),
        .i(i), .j(j), .read_data(rd_b), .write_data(write_data), .finish(finish),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .res_addr(res_addr), .res_data(res_b), .wr_count(cnt_b),
        .done(done_b), .overflow(ovf_b), .addr_err(err_b)
    );

    mm_mem_server #(.N(N), .DEPTH(DEPTH), .RDEPTH(4)) u_small (
        .clk(clk), .reset(reset), .read(read), .write(write), .index(index),
        .i(i), .j(j), .read_data(rd_s), .write_data(write_data), .finish(finish),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .res_addr(res_addr[1:0]), .res_data(res_s), .wr_count(cnt_s),
        .done(done_s), .overflow(ovf_s), .addr_err(err_s)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: memory image, result lists per buffer size, sticky flags.
    logic [N-1:0]   m_mem   [DEPTH];
    bit             m_mem_v [DEPTH];
    logic [2*N-1:0] m_res   [2][1024];
    bit             m_res_v [2][1024];
    int             m_cnt   [2];
    bit             m_ovf   [2];
    int             dep     [2] = '{1024, 4};
    bit             m_done, m_err, m_fq;
    logic [N-1:0]   e_rd;
    bit             e_rd_v = 1'b0;
    logic [2*N-1:0] e_res   [2];
    bit             e_res_v [2] = '{1'b0, 1'b0};
    bit             m_live = 1'b0;
    longint         a;
    int             ra [2];

    always @(posedge clk) begin
        ra[0] = int'(res_addr);
        ra[1] = int'(res_addr[1:0]);
        if (reset) begin
            e_rd = '0; e_rd_v = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e_res[k] = '0; e_res_v[k] = 1'b1; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            end
            m_done = 1'b0; m_err = 1'b0; m_fq = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                e_res[k]   = m_res[k][ra[k]];
                e_res_v[k] = m_res_v[k][ra[k]];
            end
            e_rd = '0; e_rd_v = 1'b1;
            if (read) begin
                if (write) begin
                    a = (i < 3) ? longint'(i) : -1;
                end else begin
                    if (!index) a = longint'(i) * longint'(m_mem[1]) + longint'(j) + 3;
                    else        a = longint'(i) * longint'(m_mem[2]) + longint'(j) + 3
                                    + longint'(m_mem[0]) * longint'(m_mem[1]);
                    if (a >= DEPTH) begin m_err = 1'b1; a = -1; end
                end
                if (a >= 0) begin e_rd = m_mem[a]; e_rd_v = m_mem_v[a]; end
            end else if (write && !m_done) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_cnt[k] == dep[k]) m_ovf[k] = 1'b1;
                    else begin
                        m_res[k][m_cnt[k]]   = write_data;
                        m_res_v[k][m_cnt[k]] = 1'b1;
                        m_cnt[k]++;
                    end
                end
            end
            if (finish && !m_fq) m_done = 1'b1;
            m_fq = finish;
        end
        if (load_en) begin
            m_mem[load_addr]   = load_data;
            m_mem_v[load_addr] = 1'b1;
        end
        #1;
        if (m_live) begin
            if (e_rd_v) begin
                chk("model_rd_big", rd_b, e_rd);
                chk("model_rd_small", rd_s, e_rd);
            end
            chk("model_cnt_big", cnt_b, m_cnt[0]);
            chk("model_cnt_small", cnt_s, m_cnt[1]);
            chk("model_done_big", done_b, m_done);
            chk("model_done_small", done_s, m_done);
            chk("model_ovf_big", ovf_b, m_ovf[0]);
            chk("model_ovf_small", ovf_s, m_ovf[1]);
            chk("model_err_big", err_b, m_err);
            chk("model_err_small", err_s, m_err);
            if (e_res_v[0]) chk("model_res_big", res_b, e_res[0]);
            if (e_res_v[1]) chk("model_res_small", res_s, e_res[1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int hdr [3] = '{2, 3, 2};
    int wv  [4] = '{58, 64, 139, 154};

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_read_data", rd_b, 0);
        chk("rst_res_data", res_b, 0);
        chk("rst_wr_count", cnt_b, 0);
        chk("rst_done", done_b, 0);
        chk("rst_overflow", ovf_b, 0);
        chk("rst_addr_err", err_b, 0);
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            load_en = 1'b1; load_addr = 10'(k);
            load_data = (k < 3) ? N'(hdr[k]) : N'(k - 2);
            @(negedge clk);
        end
        load_en = 1'b0;

        read = 1'b1; write = 1'b1; i = 1; j = 0;
        @(negedge clk); chk("hdr_i1", rd_b, 3);
        i = 5;
        @(negedge clk); chk("hdr_i5", rd_b, 0);

        write = 1'b0; index = 1'b0; i = 1; j = 2;
        @(negedge clk); chk("read_a_addr8", rd_b, 6);
        index = 1'b1; i = 2; j = 1;
        @(negedge clk); chk("read_b_addr14", rd_b, 12);

        index = 1'b0; i = 0; j = 0;
        load_en = 1'b1; load_addr = 10'd3; load_data = 99;
        @(negedge clk); chk("rbw_old", rd_b, 1);
        load_en = 1'b0;
        @(negedge clk); chk("rbw_new", rd_b, 99);
        read = 1'b0;
        @(negedge clk); chk("idle_zero", rd_b, 0);

        for (int k = 0; k < 4; k++) begin
            write = 1'b1; write_data = 40'(wv[k]);
            @(negedge clk);
        end
        write = 1'b0; finish = 1'b1;
        @(negedge clk);
        chk("wr_count_4", cnt_b, 4);
        chk("done_set", done_b, 1);
        write = 1'b1; write_data = 999;
        @(negedge clk);
        write = 1'b0;
        chk("write_after_done", cnt_b, 4);

        for (int k = 0; k < 4; k++) begin
            res_addr = 10'(k);
            @(negedge clk); chk("res_readback", res_b, 40'(wv[k]));
        end

        read = 1'b1; index = 1'b1; i = 1023; j = 1023;
        @(negedge clk);
        chk("oob_read_zero", rd_b, 0);
        chk("oob_addr_err", err_b, 1);
        read = 1'b0; finish = 1'b0;

        write = 1'b1; write_data = 500;
        @(negedge clk);
        write_data = 501;
        @(negedge clk);
        #2 reset = 1'b1; write = 1'b0;
        #1;
        chk("async_rst_count", cnt_b, 0);
        chk("async_rst_done", done_b, 0);
        chk("async_rst_err", err_b, 0);
        @(negedge clk);
        reset = 1'b0;

        read = 1'b1; write = 1'b1; i = 0;
        @(negedge clk); chk("hdr_after_reset", rd_b, 2);
        read = 1'b0; write = 1'b0;

        for (int k = 0; k < 5; k++) begin
            write = 1'b1; write_data = 40'(11 + k);
            @(negedge clk);
        end
        write = 1'b0;
        chk("small_count_full", cnt_s, 4);
        chk("small_overflow", ovf_s, 1);
        chk("big_count_5", cnt_b, 5);
        chk("big_no_overflow", ovf_b, 0);
        res_addr = 10'd3;
        @(negedge clk); chk("small_res3", res_s, 14);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_mem_server.md
# mm_mem_server

Synthesizable memory-side responder for the matrix-multiply core's `read`/`write`/`index` bus. It holds the operand image: three header words (row1, column1, column2), then matrix A, then matrix B. It answers the core's header and operand fetches, appends each 2N-bit result word to a result buffer, and latches completion on `finish`. It sits between the MM core and a host that loads operands beforehand and reads results back afterwards.

## Interface
- `N`, default 20: operand word width; results are 2N bits.
- `DEPTH`, default 1024: operand memory words; address width `AW = clog2(DEPTH)`.
- `RDEPTH`, default 1024: result buffer words; width `RW = clog2(RDEPTH)`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `read` in 1: core read strobe.
- `write` in 1: core write strobe.
- `index` in 1: operand select; 0 = A, 1 = B.
- `i`, `j` in N: row and column indices; `i` is also the header word number.
- `read_data` out N: registered response word.
- `write_data` in 2N: result word from the core.
- `finish` in 1: core completion.
- `load_en` in 1: host write enable for operand memory.
- `load_addr` in AW: host write address.
- `load_data` in N: host write data.
- `res_addr` in RW: host result read address.
- `res_data` out 2N: result word at `res_addr`, registered with 1-cycle latency.
- `wr_count` out RW+1: number of results stored.
- `done` out 1: sticky completion flag.
- `overflow` out 1: sticky result-buffer-full drop flag.
- `addr_err` out 1: sticky out-of-range read flag.

## Operation
- Shadow registers `r1`, `c1`, `c2` update on host loads to addresses 0, 1 and 2. They are storage: not cleared by reset, same as operand memory.
- Request decode, sampled every rising edge while `reset` = 0:
  - `read & !write & !index`: address = i*c1 + j + 3.
  - `read & !write & index`: address = i*c2 + j + 3 + r1*c1.
  - `read & write` (header fetch): returns mem[i] when i < 3, otherwise 0.
  - `write & !read`: stores `write_data` at result pointer `wr_count`, then increments `wr_count`. `read_data` goes to 0.
  - Idle (neither strobe): `read_data` = 0.
- Arithmetic: addresses are computed at full product width (2N+1 bits), then range-checked against DEPTH. An out-of-range read returns 0 and sets `addr_err`.
- Result buffer full: when `wr_count` = RDEPTH, further writes are dropped, `overflow` is set and `wr_count` holds.
- `finish` rising edge (registered compare with the previous value) sets `done`. While `done` = 1, writes are ignored and `wr_count` is frozen. Reads are still served.
- Host load and core read in the same cycle: the read returns the old word (read-before-write).
- Undefined strobe combinations do not exist; all four decodes above are exhaustive.

## Timing
- Read latency is 1 cycle: request sampled at edge k, `read_data` valid from edge k+1 until edge k+2.
- A write is committed at the sampling edge. `wr_count` shows the new value after that edge.
- `res_data` is valid 1 cycle after `res_addr` changes.
- Reset values: `read_data` = 0, `res_data` = 0, `wr_count` = 0, `done` = 0, `overflow` = 0, `addr_err` = 0, finish edge register = 0.
- Reset mid-operation: all of the above return to reset values immediately (asynchronous). Operand memory, shadows and result RAM contents are retained. The first request is accepted at the first rising edge after `reset` falls.
- Back-to-back requests are accepted every cycle; no stall.

## Structure
- Package `mm_pkg`: parameter `N`, the header offset constant `HDR = 3`, and a request-kind enum `REQ_IDLE`, `REQ_A`, `REQ_B`, `REQ_HDR`, `REQ_WR`.
- Sub-module `mm_addr_gen`: combinational decode plus address multiply and range check. Outputs request kind, address and error.
- Top level holds the operand RAM, result RAM, shadows, pointer and flags.

## Test plan
- Load header 2, 3, 2; A = 1..6 at addresses 3..8; B = 7..12 at addresses 9..14. Header fetch `read & write` with i = 1 -> `read_data` = 3 one cycle later. Same fetch with i = 5 -> 0.
- `read`, index = 0, i = 1, j = 2 -> address 8 -> 6. `read`, index = 1, i = 2, j = 1 -> address 14 -> 12. Issue both back to back -> 6, then 12, on consecutive cycles.
- Four writes 58, 64, 139, 154, then `finish` -> `wr_count` = 4, `done` = 1. `res_addr` 0..3 returns 58, 64, 139, 154. A fifth write after `done` is ignored.
- With RDEPTH = 4, five writes -> `wr_count` = 4, `overflow` = 1, `res_data[3]` = 4th value.
- index = 1, i = 1023, j = 1023 -> `read_data` = 0, `addr_err` = 1.
- Assert `reset` mid write sequence after 2 writes -> `wr_count`/flags go to 0 immediately. After release, a header read with i = 0 still returns 2.
